// File: rtl/qtree_stream_loader.sv
// rtl/qtree_stream_loader.sv - postfix quad-tree token loader and kernel launcher
module qtree_stream_loader #(
    parameter int PTR_W       = 16,
    parameter int VAL_W       = 64,
    parameter int NUM_ARGS    = 2,
    parameter int STACK_DEPTH = 256,
    localparam int REC_W      = (VAL_W > 4 * PTR_W) ? VAL_W : 4 * PTR_W,
    localparam int WR_W       = REC_W + 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [VAL_W+1:0]          in_data,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      in_last,
    output logic [WR_W-1:0]           wr_data,
    output logic                      wr_valid,
    input  logic                      wr_ready,
    input  logic [PTR_W-1:0]          ptr_data,
    input  logic                      ptr_valid,
    output logic                      go_valid,
    input  logic                      go_ready,
    output logic [NUM_ARGS*PTR_W-1:0] arg_data,
    output logic [NUM_ARGS-1:0]       arg_valid,
    input  logic [NUM_ARGS-1:0]       arg_ready,
    input  logic [PTR_W-1:0]          res_in_data,
    input  logic                      res_in_valid,
    output logic                      res_in_ready,
    output logic [PTR_W-1:0]          res_data,
    output logic                      res_valid,
    input  logic                      res_ready,
    output logic                      error,
    output logic [1:0]                err_code
);

    localparam int AW = $clog2(STACK_DEPTH);
    localparam int DW = AW + 1;
    localparam int CW = $clog2(NUM_ARGS + 1);

    typedef enum logic [2:0] {ACCEPT, WRITE, WAIT_PTR, LAUNCH, RUN, HOLD, ERROR} state_t;

    state_t              state;
    logic [PTR_W-1:0]    stack_mem [STACK_DEPTH];
    logic [DW-1:0]       depth;
    logic [CW-1:0]       arg_cnt;
    logic                last_q;
    logic [PTR_W-1:0]    arg_q [NUM_ARGS];
    logic [AW-1:0]       top_idx;
    logic [4*PTR_W-1:0]  children;
    logic                full;
    logic                push_en;
    logic                go_pending;
    logic [NUM_ARGS-1:0] arg_pending;

    // child0 is the oldest of the four popped entries, child3 the most recent
    always_comb begin
        top_idx     = depth[AW-1:0] - AW'(1);
        children    = {stack_mem[top_idx - AW'(3)], stack_mem[top_idx - AW'(2)],
                       stack_mem[top_idx - AW'(1)], stack_mem[top_idx]};
        full        = (depth == DW'(STACK_DEPTH));
        push_en     = (state == WAIT_PTR) && ptr_valid && !full;
        go_pending  = go_valid & ~go_ready;
        arg_pending = arg_valid & ~arg_ready;
    end

    always_comb begin
        arg_data = '0;
        for (int k = 0; k < NUM_ARGS; k++) begin
            arg_data[k*PTR_W +: PTR_W] = arg_q[k];
        end
    end

    always_ff @(posedge clk) begin
        if (push_en) begin
            stack_mem[depth[AW-1:0]] <= ptr_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ACCEPT;
            depth        <= '0;
            arg_cnt      <= '0;
            last_q       <= 1'b0;
            in_ready     <= 1'b0;
            wr_valid     <= 1'b0;
            wr_data      <= '0;
            go_valid     <= 1'b0;
            arg_valid    <= '0;
            res_in_ready <= 1'b0;
            res_valid    <= 1'b0;
            res_data     <= '0;
            error        <= 1'b0;
            err_code     <= 2'd0;
            for (int k = 0; k < NUM_ARGS; k++) begin
                arg_q[k] <= '0;
            end
        end else begin
            case (state)
                ACCEPT: begin
                    if (!in_ready) begin
                        in_ready <= 1'b1;
                    end else if (in_valid) begin
                        in_ready <= 1'b0;
                        last_q   <= in_last;
                        if (in_data[1:0] == 2'd2) begin
                            if (depth < DW'(4)) begin
                                state    <= ERROR;
                                error    <= 1'b1;
                                err_code <= 2'd1;
                            end else begin
                                depth    <= depth - DW'(4);
                                wr_data  <= {REC_W'(children), in_data[1:0]};
                                wr_valid <= 1'b1;
                                state    <= WRITE;
                            end
                        end else begin
                            wr_data  <= {REC_W'(in_data[VAL_W+1:2]), in_data[1:0]};
                            wr_valid <= 1'b1;
                            state    <= WRITE;
                        end
                    end
                end
                WRITE: begin
                    if (wr_ready) begin
                        wr_valid <= 1'b0;
                        state    <= WAIT_PTR;
                    end
                end
                WAIT_PTR: begin
                    if (ptr_valid) begin
                        if (full) begin
                            state    <= ERROR;
                            error    <= 1'b1;
                            err_code <= 2'd2;
                        end else if (last_q) begin
                            // a well-formed tree leaves only its root: empty stack before this push
                            if (depth != '0) begin
                                state    <= ERROR;
                                error    <= 1'b1;
                                err_code <= 2'd3;
                            end else begin
                                for (int k = 0; k < NUM_ARGS; k++) begin
                                    if (arg_cnt == CW'(k)) begin
                                        arg_q[k] <= ptr_data;
                                    end
                                end
                                arg_cnt <= arg_cnt + CW'(1);
                                if (arg_cnt == CW'(NUM_ARGS - 1)) begin
                                    go_valid  <= 1'b1;
                                    arg_valid <= '1;
                                    state     <= LAUNCH;
                                end else begin
                                    in_ready <= 1'b1;
                                    state    <= ACCEPT;
                                end
                            end
                        end else begin
                            depth    <= depth + DW'(1);
                            in_ready <= 1'b1;
                            state    <= ACCEPT;
                        end
                    end
                end
                LAUNCH: begin
                    go_valid  <= go_pending;
                    arg_valid <= arg_pending;
                    if (!go_pending && (arg_pending == '0)) begin
                        res_in_ready <= 1'b1;
                        state        <= RUN;
                    end
                end
                RUN: begin
                    if (res_in_valid) begin
                        res_data     <= res_in_data;
                        res_valid    <= 1'b1;
                        res_in_ready <= 1'b0;
                        state        <= HOLD;
                    end
                end
                HOLD: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        depth     <= '0;
                        arg_cnt   <= '0;
                        in_ready  <= 1'b1;
                        state     <= ACCEPT;
                    end
                end
                ERROR: begin
                    state <= ERROR;
                end
                default: begin
                    state <= ERROR;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_qtree_stream_loader.sv
// tb/tb_qtree_stream_loader.sv - scoreboard bench for qtree_stream_loader
module tb_qtree_stream_loader;

    localparam int PTR_W       = 16;
    localparam int VAL_W       = 64;
    localparam int NUM_ARGS    = 2;
    localparam int STACK_DEPTH = 4;
    localparam int WR_W        = 66;

    logic                      clk = 1'b0;
    logic                      reset = 1'b1;
    logic [VAL_W+1:0]          in_data = '0;
    logic                      in_valid = 1'b0;
    logic                      in_ready;
    logic                      in_last = 1'b0;
    logic [WR_W-1:0]           wr_data;
    logic                      wr_valid;
    logic                      wr_ready = 1'b0;
    logic [PTR_W-1:0]          ptr_data = '0;
    logic                      ptr_valid = 1'b0;
    logic                      go_valid;
    logic                      go_ready = 1'b0;
    logic [NUM_ARGS*PTR_W-1:0] arg_data;
    logic [NUM_ARGS-1:0]       arg_valid;
    logic [NUM_ARGS-1:0]       arg_ready = '0;
    logic [PTR_W-1:0]          res_in_data = '0;
    logic                      res_in_valid = 1'b0;
    logic                      res_in_ready;
    logic [PTR_W-1:0]          res_data;
    logic                      res_valid;
    logic                      res_ready = 1'b0;
    logic                      error;
    logic [1:0]                err_code;

    int checks = 0;
    int errors = 0;

    logic [WR_W-1:0]  exp_wr_q  [$];
    logic [PTR_W-1:0] exp_arg_q [$];
    logic [PTR_W-1:0] exp_res_q [$];
    logic [PTR_W-1:0] mstk      [$];

    qtree_stream_loader #(
        .PTR_W(PTR_W), .VAL_W(VAL_W), .NUM_ARGS(NUM_ARGS), .STACK_DEPTH(STACK_DEPTH)
    ) dut (
        .clk(clk), .reset(reset),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .ptr_data(ptr_data), .ptr_valid(ptr_valid),
        .go_valid(go_valid), .go_ready(go_ready),
        .arg_data(arg_data), .arg_valid(arg_valid), .arg_ready(arg_ready),
        .res_in_data(res_in_data), .res_in_valid(res_in_valid), .res_in_ready(res_in_ready),
        .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready),
        .error(error), .err_code(err_code)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        in_valid = 1'b0; in_last = 1'b0; wr_ready = 1'b0; ptr_valid = 1'b0;
        go_ready = 1'b0; arg_ready = '0; res_in_valid = 1'b0; res_ready = 1'b0;
        @(negedge clk);
        chk("reset_ctrl", {in_ready, wr_valid, go_valid, arg_valid, res_in_ready,
                           res_valid, error, err_code}, '0);
        chk("reset_data", {wr_data, arg_data, res_data}, '0);
        reset = 1'b0;
        exp_wr_q.delete(); exp_arg_q.delete(); exp_res_q.delete(); mstk.delete();
        @(negedge clk);
        chk("in_ready_after_reset", in_ready, 1'b1);
        chk("error_after_reset", error, 1'b0);
    endtask

    task automatic drive_beat(input logic [1:0] tag, input logic [VAL_W-1:0] payload, input logic last);
        in_data  = {payload, tag};
        in_last  = last;
        in_valid = 1'b1;
        for (int n = 0; n < 20 && !in_ready; n++) @(negedge clk);
        chk("beat_ready", in_ready, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic do_write(input int stall);
        logic [WR_W-1:0] e;
        e = exp_wr_q.pop_front();
        chk("wr_valid_rise", wr_valid, 1'b1);
        for (int i = 0; i < stall; i++) begin
            chk("wr_hold_data", wr_data, e);
            chk("wr_hold_valid", wr_valid, 1'b1);
            @(negedge clk);
        end
        chk("wr_data", wr_data, e);
        wr_ready = 1'b1;
        @(negedge clk);
        wr_ready = 1'b0;
        chk("wr_valid_drop", wr_valid, 1'b0);
    endtask

    task automatic give_ptr(input logic [PTR_W-1:0] p);
        ptr_data  = p;
        ptr_valid = 1'b1;
        @(negedge clk);
        ptr_valid = 1'b0;
    endtask

    task automatic send_token(input logic [1:0] tag, input logic [VAL_W-1:0] payload,
                              input logic last, input logic [PTR_W-1:0] p, input int stall);
        logic [WR_W-1:0] e;
        if (tag == 2'd2) begin
            e = {mstk[$-3], mstk[$-2], mstk[$-1], mstk[$], tag};
            repeat (4) void'(mstk.pop_back());
        end else begin
            e = {payload, tag};
        end
        exp_wr_q.push_back(e);
        drive_beat(tag, payload, last);
        do_write(stall);
        give_ptr(p);
        if (last) exp_arg_q.push_back(p);
        else mstk.push_back(p);
        if (last && exp_arg_q.size() == NUM_ARGS) chk("go_valid_rise", go_valid, 1'b1);
        else chk("in_ready_after_push", in_ready, 1'b1);
    endtask

    task automatic launch(input logic stagger, input logic [PTR_W-1:0] res);
        logic [NUM_ARGS*PTR_W-1:0] ea;
        ea = {exp_arg_q[1], exp_arg_q[0]};
        exp_arg_q.delete();
        chk("arg_valid_rise", arg_valid, 2'b11);
        chk("arg_data", arg_data, ea);
        if (!stagger) begin
            go_ready = 1'b1; arg_ready = 2'b11;
            @(negedge clk);
            go_ready = 1'b0; arg_ready = 2'b00;
            chk("go_drop", go_valid, 1'b0);
            chk("args_drop", arg_valid, 2'b00);
            chk("run_ready", res_in_ready, 1'b1);
        end else begin
            go_ready = 1'b1;
            @(negedge clk);
            go_ready = 1'b0;
            chk("stag_go_drop", go_valid, 1'b0);
            chk("stag_args_held", arg_valid, 2'b11);
            chk("stag_not_run0", res_in_ready, 1'b0);
            chk("stag_arg_stable", arg_data, ea);
            arg_ready = 2'b01;
            @(negedge clk);
            arg_ready = 2'b00;
            chk("stag_arg0_drop", arg_valid, 2'b10);
            chk("stag_not_run1", res_in_ready, 1'b0);
            chk("stag_arg_stable1", arg_data, ea);
            arg_ready = 2'b10;
            @(negedge clk);
            arg_ready = 2'b00;
            chk("stag_arg1_drop", arg_valid, 2'b00);
            chk("stag_run", res_in_ready, 1'b1);
        end
        exp_res_q.push_back(res);
        res_in_data  = res;
        res_in_valid = 1'b1;
        @(negedge clk);
        res_in_valid = 1'b0;
        chk("res_valid_rise", res_valid, 1'b1);
        chk("res_data", res_data, exp_res_q.pop_front());
        chk("res_in_ready_drop", res_in_ready, 1'b0);
        @(negedge clk);
        chk("res_valid_hold", res_valid, 1'b1);
        chk("in_ready_during_hold", in_ready, 1'b0);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        chk("res_valid_drop", res_valid, 1'b0);
        chk("in_ready_rearm", in_ready, 1'b1);
    endtask

    task automatic check_err(input logic [1:0] code);
        chk("error_flag", error, 1'b1);
        chk("err_code", err_code, code);
        chk("err_in_ready", in_ready, 1'b0);
        chk("err_valids", {wr_valid, go_valid, arg_valid, res_in_ready, res_valid}, '0);
        in_valid = 1'b1;
        repeat (3) @(negedge clk);
        in_valid = 1'b0;
        chk("err_sticky", {error, err_code, in_ready}, {1'b1, code, 1'b0});
    endtask

    initial begin
        do_reset();

        // batch of two single-leaf trees
        send_token(2'd1, 64'd5, 1'b1, 16'h10, 0);
        send_token(2'd3, 64'd0, 1'b1, 16'h11, 0);
        launch(1'b0, 16'h42);

        // four leaves plus a node, then a stalled write and staggered launch
        send_token(2'd1, 64'hA, 1'b0, 16'd1, 0);
        send_token(2'd1, 64'hB, 1'b0, 16'd2, 0);
        send_token(2'd3, 64'd0, 1'b0, 16'd3, 0);
        send_token(2'd0, 64'd0, 1'b0, 16'd4, 0);
        send_token(2'd2, 64'd0, 1'b1, 16'd5, 0);
        send_token(2'd1, 64'hDEAD_BEEF_0123_4567, 1'b1, 16'h20, 5);
        launch(1'b1, 16'h77);

        // reset while waiting for a pointer, then a fresh batch with a stray pointer
        exp_wr_q.push_back({64'h33, 2'd1});
        drive_beat(2'd1, 64'h33, 1'b0);
        do_write(0);
        do_reset();
        give_ptr(16'h99);
        send_token(2'd1, 64'd7, 1'b1, 16'h30, 0);
        send_token(2'd0, 64'd0, 1'b1, 16'h31, 0);
        chk("no_error_after_stray_ptr", error, 1'b0);
        launch(1'b0, 16'h55);

        // underflow
        send_token(2'd1, 64'd1, 1'b0, 16'd1, 0);
        send_token(2'd1, 64'd2, 1'b0, 16'd2, 0);
        send_token(2'd1, 64'd3, 1'b0, 16'd3, 0);
        drive_beat(2'd2, 64'd0, 1'b1);
        check_err(2'd1);
        do_reset();

        // bad tree end
        send_token(2'd1, 64'd1, 1'b0, 16'h40, 0);
        exp_wr_q.push_back({64'd2, 2'd1});
        drive_beat(2'd1, 64'd2, 1'b1);
        do_write(0);
        give_ptr(16'h41);
        check_err(2'd3);
        do_reset();

        // overflow
        for (int i = 0; i < STACK_DEPTH; i++) begin
            send_token(2'd1, 64'(i), 1'b0, 16'(i + 1), 0);
        end
        exp_wr_q.push_back({64'd9, 2'd1});
        drive_beat(2'd1, 64'd9, 1'b0);
        do_write(0);
        give_ptr(16'h50);
        check_err(2'd2);
        do_reset();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/qtree_stream_loader.md
# qtree_stream_loader

Parametrised front end that turns a postfix-serialised stream of quad-tree tokens into heap-resident trees and launches the kernel on them. Each token is written to the heap through a write/pointer handshake, and returned pointers are kept on an internal stack. Each `in_last`-terminated tree becomes one root-pointer argument. After `NUM_ARGS` roots are collected, it issues Go plus all arguments, captures the kernel's result pointer, hands it to the host, and re-arms for the next batch. It sits between the host AXI-stream side and the generated kernel top.

## Interface
- `PTR_W`, 16, heap pointer width.
- `VAL_W`, 64, leaf payload width.
- `NUM_ARGS`, 2, trees (arguments) per batch, 1..8.
- `STACK_DEPTH`, 256, pointer stack entries, power of two.
- `WR_W` (derived), 2+max(VAL_W,4*PTR_W), heap record width.

Ports:
- `clk` in 1: single clock.
- `reset` in 1: asynchronous, active-high.
- `in_data` in VAL_W+2: token; [1:0] tag (0 empty leaf, 1 value leaf, 2 node, 3 full leaf); [VAL_W+1:2] payload.
- `in_valid` in 1, `in_ready` out 1, `in_last` in 1: last token of the current tree.
- `wr_data` out WR_W, `wr_valid` out 1, `wr_ready` in 1: heap write request.
- `ptr_data` in PTR_W, `ptr_valid` in 1: pointer returned for the last write.
- `go_valid` out 1, `go_ready` in 1.
- `arg_data` out NUM_ARGS*PTR_W: arg k in bits [k*PTR_W +: PTR_W].
- `arg_valid` out NUM_ARGS, `arg_ready` in NUM_ARGS.
- `res_in_data` in PTR_W, `res_in_valid` in 1, `res_in_ready` out 1.
- `res_data` out PTR_W, `res_valid` out 1, `res_ready` in 1.
- `error` out 1, `err_code` out 2: 1 underflow, 2 overflow, 3 bad tree end.

## Operation
- States: ACCEPT, WRITE, WAIT_PTR, LAUNCH, RUN, HOLD, ERROR.
- **ACCEPT**
  - `in_ready`=1.
  - On handshake, register the token and `in_last`.
  - Leaf tag: `wr_data` = {zero-extended payload, tag}.
  - Node tag: requires depth≥4, otherwise go to ERROR with code 1.
    - Pop 4 pointers; `wr_data` = {child0,child1,child2,child3,tag}, with child3 in bits [2+:PTR_W].
    - child3 = top of stack, child0 = top-3, so postfix order is preserved.
  - Go to WRITE.
- **WRITE**
  - `wr_valid`=1 and `wr_data` are held stable until `wr_ready`, then go to WAIT_PTR.
- **WAIT_PTR**
  - On `ptr_valid`, push `ptr_data`.
  - Push with depth==STACK_DEPTH: ERROR, code 2.
  - If the registered `in_last`=1: the post-push depth must be exactly 1, otherwise ERROR with code 3.
    - The root is popped into arg slot `arg_cnt`, and `arg_cnt` increments.
    - When `arg_cnt` reaches NUM_ARGS: go to LAUNCH. Otherwise: go to ACCEPT.
- **LAUNCH**
  - `go_valid` and all `arg_valid` bits rise together.
  - Each bit drops independently on its own ready.
  - When all have handshaken, go to RUN.
- **RUN**
  - `res_in_ready`=1.
  - On handshake, capture into `res_data`, set `res_valid`, go to HOLD.
- **HOLD**
  - `res_valid` held until `res_ready`.
  - Then clear the stack and `arg_cnt`, and go to ACCEPT.
- **ERROR**
  - Sticky until reset. All valids/readies are 0 and `error`=1.
- Depth counter width is log2(STACK_DEPTH)+1. Pointer arithmetic is modulo STACK_DEPTH; no wrap is ever legal because overflow/underflow are trapped first.

## Timing
- Reset value of every output is 0: `in_ready`, `wr_valid`, `wr_data`, `go_valid`, `arg_valid`, `arg_data`, `res_in_ready`, `res_valid`, `res_data`, `error`, `err_code`.
- After reset, state is ACCEPT, stack empty, `arg_cnt`=0, and `in_ready`=1 in the first cycle after reset deasserts.
- Token latency:
  - beat handshake at cycle t → `wr_valid` at t+1;
  - `wr_ready` at cycle w → `ptr_valid` is sampled from w+1;
  - push at cycle p → `in_ready` at p+1.
- Best throughput is 1 token per 3 cycles. `ptr_valid` outside WAIT_PTR is ignored.
- `go_valid`/`arg_valid` rise the cycle after the final root push. `arg_data` is stable while any `arg_valid` is high.
- `res_valid` rises the cycle after the `res_in` handshake. `in_ready` returns the cycle after the `res_ready` handshake.
- `go_ready`/`arg_ready` high the same cycle the valids rise: handshake completes that cycle, RUN next cycle.
- Reset mid-operation aborts any in-flight write and clears stack, args and error. Nothing is replayed.

## Test plan
- NUM_ARGS=2, trees "value leaf 5, last" and "full leaf, last", heap returns pointers 0x10, 0x11:
  - expect `wr_data` payloads 5 and 0 with tags 1 and 3;
  - `arg_data`={0x11,0x10} with `go_valid`;
  - `res_in_data`=0x42 → `res_data`=0x42, then `in_ready` returns.
- Tree of 4 leaves (pointers 1,2,3,4), then a node with `in_last`:
  - node `wr_data` has child0=1, child3=4, tag 2;
  - root pointer 5 lands in arg0.
- Node token with only 3 stack entries → `error`=1, `err_code`=1, `in_ready` stays 0 until reset.
- Two leaves then `in_last` (depth 2) → `err_code`=3.
- STACK_DEPTH=4, five leaf tokens without `in_last` → `err_code`=2 on the fifth push.
- Backpressure:
  - `wr_ready` low for 5 cycles: `wr_data` stable throughout;
  - staggered `arg_ready` bits: RUN entered only after the last handshake;
  - reset asserted in WAIT_PTR: all outputs 0 and a fresh batch loads correctly.
